port_ctrl: RTL and testbench

Sequences all neighbor-port traffic for one TIS-100 node. It takes the decoded read (rx) and write (tx) requests for the current instruction and runs valid/ready handshakes on the four directional ports, resolving ANY and LAST. It returns the received word and completion strobes, and holds the PC stalled until the instruction's port traffic has finished. It sits between control/datapath and the node's four neighbor links.

---
 rtl/types_pkg.sv | 54 +++++
 rtl/port_prio_pick.sv | 29 ++
 rtl/port_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_port_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types for the TIS-100 node: word, port selects, directions, port_ctrl states.
package types_pkg;

  localparam int unsigned WORD_W = 11;
  localparam int unsigned NDIR   = 4;

  typedef logic signed [WORD_W-1:0] word_t;
  typedef logic [1:0]               dir_t;

  typedef enum logic [2:0] {
    P_NIL, P_ACC, P_UP, P_DOWN, P_LEFT, P_RIGHT, P_ANY, P_LAST
  } port_t;

  localparam dir_t D_UP    = 2'd0;
  localparam dir_t D_DOWN  = 2'd1;
  localparam dir_t D_LEFT  = 2'd2;
  localparam dir_t D_RIGHT = 2'd3;

  // ANY priority / rotation order; element 0 is offered first
  localparam logic [NDIR-1:0][1:0] ANY_ORDER = {D_DOWN, D_UP, D_RIGHT, D_LEFT};

  typedef enum logic [1:0] {
    ST_IDLE, ST_RX_WAIT, ST_TX_WAIT, ST_DONE
  } pctl_state_t;

  function automatic logic [NDIR-1:0] dir_onehot(input dir_t d);
    return NDIR'(1) << d;
  endfunction

  // Zero mask means the port has no neighbor traffic (NIL, ACC, unresolved LAST)
  function automatic logic [NDIR-1:0] port_mask(input port_t p, input logic last_vld,
                                                input dir_t last_dir);
    case (p)
      P_UP:    return dir_onehot(D_UP);
      P_DOWN:  return dir_onehot(D_DOWN);
      P_LEFT:  return dir_onehot(D_LEFT);
      P_RIGHT: return dir_onehot(D_RIGHT);
      P_ANY:   return '1;
      P_LAST:  return last_vld ? dir_onehot(last_dir) : '0;
      default: return '0;
    endcase
  endfunction

  function automatic dir_t port_dir(input port_t p, input dir_t last_dir);
    case (p)
      P_UP:    return D_UP;
      P_DOWN:  return D_DOWN;
      P_LEFT:  return D_LEFT;
      P_RIGHT: return D_RIGHT;
      default: return last_dir;
    endcase
  endfunction

endpackage

// File: rtl/port_prio_pick.sv
// Fixed-priority pick LEFT > RIGHT > UP > DOWN: one-hot grant plus winning index.
module port_prio_pick
  import types_pkg::*;
(
  input  logic [NDIR-1:0] req,
  output logic [NDIR-1:0] gnt,
  output dir_t            idx,
  output logic            any
);

  always_comb begin
    gnt = '0;
    idx = D_LEFT;
    any = 1'b1;
    if (req[D_LEFT]) begin
      idx = D_LEFT;
    end else if (req[D_RIGHT]) begin
      idx = D_RIGHT;
    end else if (req[D_UP]) begin
      idx = D_UP;
    end else if (req[D_DOWN]) begin
      idx = D_DOWN;
    end else begin
      any = 1'b0;
    end
    if (any) gnt = dir_onehot(idx);
  end

endmodule

// File: rtl/port_ctrl.sv
// Neighbor-port sequencer: runs rx/tx valid/ready handshakes, resolves ANY/LAST, stalls PC.
module port_ctrl
  import types_pkg::*;
(
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   rx,
  input  port_t                  rx_port,
  input  logic                   tx,
  input  port_t                  tx_port,
  input  word_t                  tx_data,
  output word_t                  rx_data,
  output logic                   rx_complete,
  output logic                   tx_complete,
  output logic                   pc_stall,
  output logic [NDIR-1:0]        out_valid,
  output word_t                  out_data,
  input  logic [NDIR-1:0]        out_ready,
  input  logic [NDIR-1:0]        in_valid,
  input  logic [NDIR*WORD_W-1:0] in_data,
  output logic [NDIR-1:0]        in_ready
);

  pctl_state_t     state_q, state_d;
  logic            rx_pend_q, rx_pend_d, tx_pend_q, tx_pend_d, tx_live_q, tx_live_d;
  logic            tx_any_q, tx_any_d, last_vld_q, last_vld_d;
  logic            rx_cmp_q, rx_cmp_d, tx_cmp_q, tx_cmp_d;
  logic [NDIR-1:0] rx_mask_q, rx_mask_d, out_valid_q, out_valid_d;
  dir_t            tx_dir_q, tx_dir_d, last_dir_q, last_dir_d, rot_q, rot_d;
  word_t           out_data_q, out_data_d, rx_data_q, rx_data_d;

  logic [NDIR-1:0] rx_req_mask, tx_req_mask, pick_gnt;
  dir_t            pick_idx;
  logic            pick_any;
  word_t           in_word;

  assign rx_req_mask = port_mask(rx_port, last_vld_q, last_dir_q);
  assign tx_req_mask = port_mask(tx_port, last_vld_q, last_dir_q);
  assign in_word     = word_t'(in_data[WORD_W*32'(pick_idx) +: WORD_W]);

  port_prio_pick u_pick (
    .req (rx_mask_q & in_valid),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign in_ready    = (state_q == ST_RX_WAIT) ? pick_gnt : '0;
  assign pc_stall    = ((state_q == ST_IDLE) && (rx || tx)) ||
                       (state_q == ST_RX_WAIT) || (state_q == ST_TX_WAIT);
  assign rx_data     = rx_data_q;
  assign rx_complete = rx_cmp_q;
  assign tx_complete = tx_cmp_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;

  always_comb begin
    state_d     = state_q;
    rx_pend_d   = rx_pend_q;
    tx_pend_d   = tx_pend_q;
    tx_live_d   = tx_live_q;
    tx_any_d    = tx_any_q;
    tx_dir_d    = tx_dir_q;
    rx_mask_d   = rx_mask_q;
    rot_d       = rot_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rx_data_d   = rx_data_q;
    last_vld_d  = last_vld_q;
    last_dir_d  = last_dir_q;
    rx_cmp_d    = 1'b0;
    tx_cmp_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx || tx) begin
          rx_pend_d = rx;
          tx_pend_d = tx;
          rx_mask_d = rx ? rx_req_mask : '0;
          tx_live_d = tx && (tx_req_mask != '0);
          tx_any_d  = (tx_port == P_ANY);
          tx_dir_d  = port_dir(tx_port, last_dir_q);
          rot_d     = '0;
          if (rx && (rx_req_mask != '0)) begin
            state_d = ST_RX_WAIT;
          end else begin
            if (rx) rx_data_d = '0;
            if (tx_live_d) begin
              // A null source (MOV NIL,dst) sends zero, never tx_data
              state_d     = ST_TX_WAIT;
              out_data_d  = rx ? '0 : tx_data;
              out_valid_d = tx_any_d ? dir_onehot(ANY_ORDER[0]) : dir_onehot(tx_dir_d);
            end else begin
              state_d  = ST_DONE;
              rx_cmp_d = rx;
              tx_cmp_d = tx;
            end
          end
        end
      end

      ST_RX_WAIT: begin
        if (pick_any) begin
          rx_data_d = in_word;
          if (rx_mask_q == '1) begin
            last_vld_d = 1'b1;
            last_dir_d = pick_idx;
          end
          if (tx_live_q) begin
            state_d     = ST_TX_WAIT;
            out_data_d  = in_word;
            out_valid_d = tx_any_q ? dir_onehot(ANY_ORDER[0]) : dir_onehot(tx_dir_q);
          end else begin
            state_d  = ST_DONE;
            rx_cmp_d = rx_pend_q;
            tx_cmp_d = tx_pend_q;
          end
        end
      end

      ST_TX_WAIT: begin
        if ((out_valid_q & out_ready) != '0) begin
          state_d     = ST_DONE;
          out_valid_d = '0;
          rx_cmp_d    = rx_pend_q;
          tx_cmp_d    = tx_pend_q;
          if (tx_any_q) begin
            last_vld_d = 1'b1;
            last_dir_d = ANY_ORDER[rot_q];
          end
        end else if (tx_any_q) begin
          // Withdraw and move the single offer on, so only one neighbor can ever take it
          rot_d       = rot_q + 2'd1;
          out_valid_d = dir_onehot(ANY_ORDER[rot_d]);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      rx_pend_q   <= 1'b0;
      tx_pend_q   <= 1'b0;
      tx_live_q   <= 1'b0;
      tx_any_q    <= 1'b0;
      tx_dir_q    <= D_UP;
      rx_mask_q   <= '0;
      rot_q       <= '0;
      out_valid_q <= '0;
      out_data_q  <= '0;
      rx_data_q   <= '0;
      last_vld_q  <= 1'b0;
      last_dir_q  <= D_UP;
      rx_cmp_q    <= 1'b0;
      tx_cmp_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_pend_q   <= rx_pend_d;
      tx_pend_q   <= tx_pend_d;
      tx_live_q   <= tx_live_d;
      tx_any_q    <= tx_any_d;
      tx_dir_q    <= tx_dir_d;
      rx_mask_q   <= rx_mask_d;
      rot_q       <= rot_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rx_data_q   <= rx_data_d;
      last_vld_q  <= last_vld_d;
      last_dir_q  <= last_dir_d;
      rx_cmp_q    <= rx_cmp_d;
      tx_cmp_q    <= tx_cmp_d;
    end
  end

endmodule

// File: tb/tb_port_ctrl.sv
// Directed bench for port_ctrl: hand-computed cycle-by-cycle expectations per scenario.
module tb_port_ctrl;
  import types_pkg::*;

  logic                   CLK = 1'b0;
  logic                   nRST;
  logic                   rx, tx;
  port_t                  rx_port, tx_port;
  word_t                  tx_data;
  word_t                  rx_data;
  logic                   rx_complete, tx_complete, pc_stall;
  logic [NDIR-1:0]        out_valid, out_ready, in_valid, in_ready;
  word_t                  out_data;
  logic [NDIR*WORD_W-1:0] in_data;

  int n_checks = 0;
  int n_pass   = 0;

  port_ctrl dut (
    .CLK(CLK), .nRST(nRST),
    .rx(rx), .rx_port(rx_port), .tx(tx), .tx_port(tx_port), .tx_data(tx_data),
    .rx_data(rx_data), .rx_complete(rx_complete), .tx_complete(tx_complete),
    .pc_stall(pc_stall), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance to 2 time units after the next rising edge
  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic set_word(input dir_t d, input word_t w);
    in_data[WORD_W*32'(d) +: WORD_W] = w;
  endtask

  initial begin
    nRST = 1'b0; rx = 1'b0; tx = 1'b0; rx_port = P_NIL; tx_port = P_NIL;
    tx_data = '0; out_ready = '0; in_valid = '0; in_data = '0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_rx_data",   32'(rx_data),   32'h0);
    check("rst_strobes",   32'({rx_complete, tx_complete}), 32'h0);
    check("rst_pc_stall",  32'(pc_stall),  32'h0);
    nRST = 1'b1;
    cyc();

    // LAST before any ANY transfer: no port activity, completes in cycle 1
    rx = 1'b1; rx_port = P_LAST; in_valid = '1; #1;
    check("last0_stall_c0", 32'(pc_stall), 32'h1);
    cyc(); #1;
    check("last0_rxc_c1",   32'(rx_complete), 32'h1);
    check("last0_rdy_c1",   32'(in_ready),    32'h0);
    check("last0_data",     32'(rx_data),     32'h0);
    rx = 1'b0; in_valid = '0;
    cyc();

    // Direct read UP, neighbor offers -42 in cycle 3
    rx = 1'b1; rx_port = P_UP; #1;
    check("rd_stall_c0", 32'(pc_stall), 32'h1);
    cyc(); #1;
    check("rd_stall_c1", 32'(pc_stall), 32'h1);
    check("rd_rdy_c1",   32'(in_ready), 32'h0);
    cyc(); #1;
    check("rd_stall_c2", 32'(pc_stall), 32'h1);
    cyc();
    in_valid = 4'b0001; set_word(D_UP, word_t'(-42)); #1;
    check("rd_rdy_c3",   32'(in_ready), 32'h1);
    check("rd_stall_c3", 32'(pc_stall), 32'h1);
    check("rd_rxc_c3",   32'(rx_complete), 32'h0);
    cyc();
    in_valid = '0; #1;
    check("rd_rxc_c4",   32'(rx_complete), 32'h1);
    check("rd_data",     32'(rx_data), 32'(word_t'(-42)));
    check("rd_stall_c4", 32'(pc_stall), 32'h0);
    rx = 1'b0;
    cyc(); #1;
    check("rd_rxc_c5",   32'(rx_complete), 32'h0);

    // NIL read zeroes rx_data in cycle 1
    rx = 1'b1; rx_port = P_NIL;
    cyc(); #1;
    check("nil_rxc_c1",  32'(rx_complete), 32'h1);
    check("nil_data",    32'(rx_data), 32'h0);
    check("nil_ovalid",  32'(out_valid), 32'h0);
    rx = 1'b0;
    cyc();

    // ANY read with RIGHT and DOWN valid together: RIGHT wins
    rx = 1'b1; rx_port = P_ANY;
    cyc();
    in_valid = 4'b1010; set_word(D_RIGHT, word_t'(100)); set_word(D_DOWN, word_t'(200)); #1;
    check("any_rd_rdy",      32'(in_ready), 32'b1000);
    check("any_rd_down_rdy", 32'(in_ready[D_DOWN]), 32'h0);
    cyc();
    in_valid = '0; #1;
    check("any_rd_rxc",  32'(rx_complete), 32'h1);
    check("any_rd_data", 32'(rx_data), 32'(word_t'(100)));
    rx = 1'b0;
    cyc();

    // LAST now resolves to RIGHT even with every neighbor offering
    rx = 1'b1; rx_port = P_LAST;
    cyc();
    in_valid = 4'b1111;
    set_word(D_UP, word_t'(1)); set_word(D_DOWN, word_t'(2));
    set_word(D_LEFT, word_t'(3)); set_word(D_RIGHT, word_t'(4)); #1;
    check("last_rdy", 32'(in_ready), 32'b1000);
    cyc();
    in_valid = '0; #1;
    check("last_rxc",  32'(rx_complete), 32'h1);
    check("last_data", 32'(rx_data), 32'(word_t'(4)));
    rx = 1'b0;
    cyc();

    // ANY write of 999, only DOWN ready: offer rotates LEFT, RIGHT, UP, DOWN
    tx = 1'b1; tx_port = P_ANY; tx_data = word_t'(999); out_ready = 4'b0010;
    cyc(); #1;
    check("any_wr_c1_valid", 32'(out_valid), 32'b0100);
    check("any_wr_c1_data",  32'(out_data), 32'(word_t'(999)));
    cyc(); #1;
    check("any_wr_c2_valid", 32'(out_valid), 32'b1000);
    cyc(); #1;
    check("any_wr_c3_valid", 32'(out_valid), 32'b0001);
    cyc(); #1;
    check("any_wr_c4_valid", 32'(out_valid), 32'b0010);
    check("any_wr_c4_txc",   32'(tx_complete), 32'h0);
    cyc(); #1;
    check("any_wr_c5_txc",   32'(tx_complete), 32'h1);
    check("any_wr_c5_valid", 32'(out_valid), 32'h0);
    tx = 1'b0; out_ready = '0;
    cyc();

    // MOV LEFT,RIGHT: forwarded word 7, tx_data 123 ignored, both strobes together
    rx = 1'b1; rx_port = P_LEFT; tx = 1'b1; tx_port = P_RIGHT; tx_data = word_t'(123);
    cyc();
    in_valid = 4'b0100; set_word(D_LEFT, word_t'(7)); #1;
    check("mov_rdy_c1",    32'(in_ready), 32'b0100);
    check("mov_valid_c1",  32'(out_valid), 32'h0);
    cyc();
    in_valid = '0; out_ready = 4'b1000; #1;
    check("mov_valid_c2",  32'(out_valid), 32'b1000);
    check("mov_data_c2",   32'(out_data), 32'(word_t'(7)));
    check("mov_strb_c2",   32'({rx_complete, tx_complete}), 32'h0);
    cyc(); #1;
    check("mov_strb_c3",   32'({rx_complete, tx_complete}), 32'h3);
    check("mov_valid_c3",  32'(out_valid), 32'h0);
    rx = 1'b0; tx = 1'b0; out_ready = '0;
    cyc();

    // Reset while offering on UP: withdrawn asynchronously, no completion
    tx = 1'b1; tx_port = P_UP; tx_data = word_t'(55);
    cyc(); #1;
    check("rst_mid_valid_c1", 32'(out_valid), 32'b0001);
    cyc(); #1;
    nRST = 1'b0; tx = 1'b0; #1;
    check("rst_mid_async",  32'(out_valid), 32'h0);
    check("rst_mid_txc",    32'(tx_complete), 32'h0);
    #2 nRST = 1'b1;
    cyc(); #1;
    check("rst_mid_idle_stall", 32'(pc_stall), 32'h0);
    check("rst_mid_idle_txc",   32'(tx_complete), 32'h0);
    check("rst_mid_idle_valid", 32'(out_valid), 32'h0);

    // Fresh direct write after reset starts from IDLE and completes at the earliest
    tx = 1'b1; tx_port = P_UP; tx_data = word_t'(-5); out_ready = 4'b0001;
    cyc(); #1;
    check("post_wr_valid_c1", 32'(out_valid), 32'b0001);
    check("post_wr_data_c1",  32'(out_data), 32'(word_t'(-5)));
    cyc(); #1;
    check("post_wr_txc_c2",   32'(tx_complete), 32'h1);
    tx = 1'b0; out_ready = '0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
